// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the toggle request/acknowledge CDC blocks (rx now, tx later).
package cdc_hs_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      VLD  = 1'b1
   } state_e;

   // Both sides must come out of reset with matching toggles.
   localparam logic ACK_RST = 1'b0;

endpackage

// File: rtl/cdc_hs_rx.sv
// Receive side of a toggle req/ack CDC: captures the held payload and hands it to a valid/ready consumer.
// Optional protocol-violation detector enabled by defining CDC_HS_RX_ERR_EN.
module cdc_hs_rx
   import cdc_hs_pkg::*;
#(
   parameter int W     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_sync,
   input  logic [W-1:0]     data_in,
   output logic             ack,
   output logic             out_vld,
   output logic [W-1:0]     out_data,
   input  logic             out_rdy,
   output logic [CNT_W-1:0] xfer_cnt,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e state;

   // A request is pending whenever the synchronized toggle differs from our ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ack      <= ACK_RST;
         out_vld  <= 1'b0;
         out_data <= '0;
         xfer_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_sync != ack) begin
                  out_data <= data_in;
                  out_vld  <= 1'b1;
                  state    <= VLD;
               end
            end
            VLD: begin
               if (out_rdy) begin
                  ack      <= ~ack;
                  xfer_cnt <= xfer_cnt + CNT_ONE;
                  out_vld  <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CDC_HS_RX_ERR_EN
   logic req_q;
   logic err_q;
   logic viol;

   // Any toggle seen while holding a word means the source did not wait for ack.
   assign viol = (state == VLD) && (req_sync != req_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         req_q <= req_sync;
         if (viol)
            err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         assert (!viol) else $warning("cdc_hs_rx: request re-toggled before ack");
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
